// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V control unit: decodes Op/Funct3/Funct7 from the IR and
// sequences the shared PC/IR/ULA/memory datapath with a Moore FSM.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | read instruction at PC, load IR/OldPC, PC <= PC+4
// DECODE   | read registers, ALUOut <= OldPC+Imm (branch/jump target)
// MEMADR   | ALUOut <= RD1+Imm (load/store address)
// MEMREAD  | read data memory at ALUOut, wait for MemReady
// MEMWB    | rd <= loaded data
// MEMWRITE | write data memory at ALUOut, wait for MemReady
// EXECR    | ALUOut <= RD1 op RD2
// EXECI    | ALUOut <= RD1 op Imm
// ALUWB    | rd <= ALUOut
// BRANCH   | compare RD1-RD2, PC <= ALUOut when taken
// JAL      | PC <= ALUOut, ALUOut <= OldPC+4
// TRAP     | illegal instruction, absorbing until reset
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Op,
  input  logic [2:0] Funct3,
  input  logic [6:0] Funct7,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ULASrcA,
  output logic [1:0] ULASrcB,
  output logic [2:0] ULAControl,
  output logic [1:0] ImmSrc,
  output logic       Trap,
  output logic       Retire
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [3:0] state_q, state_d;
  logic       r_ok;
  logic [2:0] r_ctl;

  // State register; reset returns to FETCH immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // R-type legality and ALU operation from {Funct3,Funct7}
  always_comb begin
    r_ok  = 1'b1;
    r_ctl = 3'b000;
    case ({Funct3, Funct7})
      {3'b000, 7'b0000000}: r_ctl = 3'b000;
      {3'b000, 7'b0100000}: r_ctl = 3'b001;
      {3'b111, 7'b0000000}: r_ctl = 3'b010;
      {3'b110, 7'b0000000}: r_ctl = 3'b011;
      {3'b100, 7'b0000000}: r_ctl = 3'b100;
      {3'b010, 7'b0000000}: r_ctl = 3'b101;
      default:              r_ok  = 1'b0;
    endcase
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_TRAP;
        case (Op)
          OP_LOAD:   if (Funct3 == 3'b000) state_d = S_MEMADR;
          OP_STORE:  if (Funct3 == 3'b000) state_d = S_MEMADR;
          OP_RTYPE:  if (r_ok) state_d = S_EXECR;
          OP_ITYPE:  if (Funct3 == 3'b000 || Funct3 == 3'b110) state_d = S_EXECI;
          OP_BRANCH: if (Funct3 == 3'b000 || Funct3 == 3'b001) state_d = S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          default:   state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (Op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (MemReady) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    case (Op)
      OP_LOAD, OP_ITYPE: ImmSrc = 2'b00;
      OP_STORE:          ImmSrc = 2'b01;
      OP_BRANCH:         ImmSrc = 2'b10;
      OP_JAL:            ImmSrc = 2'b11;
      default:           ImmSrc = 2'b00;
    endcase
  end

  // Per-state datapath controls; strobes are gated off while reset is high
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ULASrcA    = 2'b00;
    ULASrcB    = 2'b00;
    ULAControl = 3'b000;
    Trap       = 1'b0;
    Retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ResultSrc = 2'b10;
        ULASrcB   = 2'b10;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
      end
      S_DECODE: begin
        ULASrcA = 2'b01;
        ULASrcB = 2'b01;
      end
      S_MEMADR: begin
        ULASrcA = 2'b10;
        ULASrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        Retire    = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        Retire   = MemReady;
      end
      S_EXECR: begin
        ULASrcA    = 2'b10;
        ULAControl = r_ctl;
      end
      S_EXECI: begin
        ULASrcA    = 2'b10;
        ULASrcB    = 2'b01;
        ULAControl = (Funct3 == 3'b110) ? 3'b011 : 3'b000;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        Retire   = 1'b1;
      end
      S_BRANCH: begin
        ULASrcA    = 2'b10;
        ULAControl = 3'b001;
        Retire     = 1'b1;
        PCWrite    = ((Funct3 == 3'b000) && Zero) || ((Funct3 == 3'b001) && !Zero);
      end
      S_JAL: begin
        ULASrcA = 2'b01;
        ULASrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_TRAP:  Trap = 1'b1;
      default: ;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      Retire   = 1'b0;
      Trap     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboarded bench for multicycle_control_fsm: stimulus pushes the expected
// output vector for each cycle, a monitor pops and compares on the falling edge.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] Op;
  logic [2:0] Funct3;
  logic [6:0] Funct7;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Trap, Retire;
  logic [1:0] ResultSrc, ULASrcA, ULASrcB, ImmSrc;
  logic [2:0] ULAControl;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct3(Funct3), .Funct7(Funct7),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ULASrcA(ULASrcA), .ULASrcB(ULASrcB),
    .ULAControl(ULAControl), .ImmSrc(ImmSrc), .Trap(Trap), .Retire(Retire)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] v;
    string       nm;
  } exp_t;

  exp_t       sb_q[$];
  int         tests_run = 0;
  int         tests_failed = 0;
  int         retire_seen = 0;
  int         retire_exp = 0;
  logic [1:0] cur_imm;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ULASrcA,ULASrcB,ULAControl,ImmSrc,Trap,Retire}
  function automatic logic [17:0] ov(input logic pcw, adr, mw, irw, rw,
                                     input logic [1:0] rs, sa, sb,
                                     input logic [2:0] ctl,
                                     input logic tr, ret);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, ctl, cur_imm, tr, ret};
  endfunction

  function automatic logic [17:0] e_rst();             return ov(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,0,0); endfunction
  function automatic logic [17:0] e_fetch(logic mr);   return ov(mr,0,0,mr,0,2'b10,2'b00,2'b10,3'b000,0,0); endfunction
  function automatic logic [17:0] e_dec();             return ov(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,0); endfunction
  function automatic logic [17:0] e_memadr();          return ov(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,0); endfunction
  function automatic logic [17:0] e_memrd();           return ov(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0); endfunction
  function automatic logic [17:0] e_memwb();           return ov(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,0,1); endfunction
  function automatic logic [17:0] e_memwr(logic mr);   return ov(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,0,mr); endfunction
  function automatic logic [17:0] e_execr(logic [2:0] c); return ov(0,0,0,0,0,2'b00,2'b10,2'b00,c,0,0); endfunction
  function automatic logic [17:0] e_execi(logic [2:0] c); return ov(0,0,0,0,0,2'b00,2'b10,2'b01,c,0,0); endfunction
  function automatic logic [17:0] e_aluwb();           return ov(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,0,1); endfunction
  function automatic logic [17:0] e_branch(logic p);   return ov(p,0,0,0,0,2'b00,2'b10,2'b00,3'b001,0,1); endfunction
  function automatic logic [17:0] e_jal();             return ov(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,0,0); endfunction
  function automatic logic [17:0] e_trap();            return ov(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,1,0); endfunction

  task automatic step(input logic [17:0] v, input string nm);
    exp_t e;
    e.v  = v;
    e.nm = nm;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [1:0] imm);
    Op = op; Funct3 = f3; Funct7 = f7; cur_imm = imm;
  endtask

  // Monitor: compare the full control vector against the scoreboard head
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [17:0] act;
      e   = sb_q.pop_front();
      act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ULASrcA,
             ULASrcB, ULAControl, ImmSrc, Trap, Retire};
      tests_run++;
      if (Retire === 1'b1) retire_seen++;
      if (act !== e.v) begin
        tests_failed++;
        $display("FAIL %s: got %b expected %b (t=%0t)", e.nm, act, e.v, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rf3 [6];
    logic [6:0] rf7 [6];
    logic [2:0] rctl[6];
    rf3  = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b100, 3'b010};
    rf7  = '{7'b0000000, 7'b0100000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
    rctl = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101};

    reset = 1'b1; MemReady = 1'b1; Zero = 1'b0;
    set_instr(7'b0110011, 3'b000, 7'b0000000, 2'b00);
    @(posedge clk); #1;
    step(e_rst(), "reset_state");
    reset = 1'b0;

    // R-type table, ADD first
    for (int i = 0; i < 6; i++) begin
      set_instr(7'b0110011, rf3[i], rf7[i], 2'b00);
      step(e_fetch(1), "r_fetch");
      step(e_dec(), "r_decode");
      step(e_execr(rctl[i]), "r_execr");
      step(e_aluwb(), "r_aluwb");
      retire_exp++;
    end

    // ADDI then ORI, with one FETCH wait on the first
    set_instr(7'b0010011, 3'b000, 7'b0000000, 2'b00);
    MemReady = 1'b0; step(e_fetch(0), "addi_fetch_wait");
    MemReady = 1'b1; step(e_fetch(1), "addi_fetch");
    step(e_dec(), "addi_decode");
    step(e_execi(3'b000), "addi_execi");
    step(e_aluwb(), "addi_aluwb");
    retire_exp++;
    set_instr(7'b0010011, 3'b110, 7'b0000000, 2'b00);
    step(e_fetch(1), "ori_fetch");
    step(e_dec(), "ori_decode");
    step(e_execi(3'b011), "ori_execi");
    step(e_aluwb(), "ori_aluwb");
    retire_exp++;

    // LB with two MEMREAD waits: 7 cycles
    set_instr(7'b0000011, 3'b000, 7'b0000000, 2'b00);
    step(e_fetch(1), "lb_fetch");
    step(e_dec(), "lb_decode");
    step(e_memadr(), "lb_memadr");
    MemReady = 1'b0;
    step(e_memrd(), "lb_memread_wait1");
    step(e_memrd(), "lb_memread_wait2");
    MemReady = 1'b1;
    step(e_memrd(), "lb_memread_done");
    step(e_memwb(), "lb_memwb");
    retire_exp++;

    // Branches: {funct3, Zero, taken}
    begin
      logic [2:0] bf3 [4];
      logic       bz  [4];
      logic       bt  [4];
      bf3 = '{3'b001, 3'b000, 3'b000, 3'b001};
      bz  = '{1'b0, 1'b0, 1'b1, 1'b1};
      bt  = '{1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
        set_instr(7'b1100011, bf3[i], 7'b0000000, 2'b10);
        Zero = bz[i];
        step(e_fetch(1), "br_fetch");
        step(e_dec(), "br_decode");
        step(e_branch(bt[i]), "br_branch");
        retire_exp++;
      end
      Zero = 1'b0;
    end

    // JAL
    set_instr(7'b1101111, 3'b000, 7'b0000000, 2'b11);
    step(e_fetch(1), "jal_fetch");
    step(e_dec(), "jal_decode");
    step(e_jal(), "jal_jal");
    step(e_aluwb(), "jal_aluwb");
    retire_exp++;

    // SB with three MEMWRITE waits: MemWrite high 4 cycles
    set_instr(7'b0100011, 3'b000, 7'b0000000, 2'b01);
    step(e_fetch(1), "sb_fetch");
    step(e_dec(), "sb_decode");
    step(e_memadr(), "sb_memadr");
    MemReady = 1'b0;
    step(e_memwr(0), "sb_memwrite_wait1");
    step(e_memwr(0), "sb_memwrite_wait2");
    step(e_memwr(0), "sb_memwrite_wait3");
    MemReady = 1'b1;
    step(e_memwr(1), "sb_memwrite_done");
    retire_exp++;

    // SB interrupted by reset while waiting
    step(e_fetch(1), "sbr_fetch");
    step(e_dec(), "sbr_decode");
    step(e_memadr(), "sbr_memadr");
    MemReady = 1'b0;
    step(e_memwr(0), "sbr_memwrite_wait");
    reset = 1'b1; MemReady = 1'b1;
    step(e_rst(), "sbr_reset_midwait");
    reset = 1'b0;
    set_instr(7'b0010011, 3'b000, 7'b0000000, 2'b00);
    step(e_fetch(1), "post_reset_fetch");
    step(e_dec(), "post_reset_decode");
    step(e_execi(3'b000), "post_reset_execi");
    step(e_aluwb(), "post_reset_aluwb");
    retire_exp++;

    // Unsupported opcode traps; reset clears it
    set_instr(7'b0110111, 3'b000, 7'b0000000, 2'b00);
    step(e_fetch(1), "lui_fetch");
    step(e_dec(), "lui_decode");
    step(e_trap(), "lui_trap1");
    Zero = 1'b1;
    step(e_trap(), "lui_trap2");
    MemReady = 1'b0;
    step(e_trap(), "lui_trap3");
    reset = 1'b1; MemReady = 1'b1;
    step(e_rst(), "lui_reset");
    reset = 1'b0; Zero = 1'b0;

    // R-type with Funct7=0000001 traps
    set_instr(7'b0110011, 3'b000, 7'b0000001, 2'b00);
    step(e_fetch(1), "mul_fetch");
    step(e_dec(), "mul_decode");
    step(e_trap(), "mul_trap1");
    step(e_trap(), "mul_trap2");
    reset = 1'b1;
    step(e_rst(), "mul_reset");
    reset = 1'b0;
    set_instr(7'b0110011, 3'b000, 7'b0000000, 2'b00);
    step(e_fetch(1), "resume_fetch");
    step(e_dec(), "resume_decode");
    step(e_execr(3'b000), "resume_execr");
    step(e_aluwb(), "resume_aluwb");
    retire_exp++;

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
    #1;
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    tests_run++;
    if (retire_seen != retire_exp) begin
      tests_failed++;
      $display("FAIL retire_count: got %0d expected %0d", retire_seen, retire_exp);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

- Sequencing controller for the multicycle RISC-V datapath: one instruction takes 3–5 cycles over shared PC/IR/ULA/memory resources.
- Decodes Op/Funct3/Funct7 from the instruction register and walks a Moore FSM that drives every datapath strobe and mux select.
- Single unified instruction/data memory port with a ready handshake; unsupported encodings park the core in a sticky trap state.

## Interface
Parameters:
- (none)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- Op  in  7  IR[6:0]
- Funct3  in  3  IR[14:12]
- Funct7  in  7  IR[31:25]
- Zero  in  1  ULA zero flag
- MemReady  in  1  memory access completes this cycle
- PCWrite  out  1  PC load enable
- AdrSrc  out  1  memory address: 0 PC, 1 Result
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR and OldPC load enable
- RegWrite  out  1  register-file write
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ULA result
- ULASrcA  out  2  00 PC, 01 OldPC, 10 RD1
- ULASrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
- ULAControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- Trap  out  1  sticky illegal-instruction flag
- Retire  out  1  one-cycle pulse per completed instruction

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
- ImmSrc is combinational from Op in every state:
  - 0000011/0010011 → 00
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - else 00
- Default for every output not listed for a state: 0.
- FETCH: AdrSrc=0, ULASrcA=00, ULASrcB=10, ULAControl=000, ResultSrc=10.
  - IRWrite = PCWrite = MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE: ULASrcA=01, ULASrcB=01, ULAControl=000 (branch/jump target into ALUOut).
  - Next state by instruction:
    - 0000011 with Funct3=000 (LB) → MEMADR
    - 0100011 with Funct3=000 (SB) → MEMADR
    - 0110011 with a supported {Funct3,Funct7} → EXECR
    - 0010011 with Funct3 000 (ADDI) or 110 (ORI) → EXECI
    - 1100011 with Funct3 000 (BEQ) or 001 (BNE) → BRANCH
    - 1101111 → JAL
    - anything else → TRAP
  - Supported R-type {Funct3,Funct7}: ADD 000/0000000, SUB 000/0100000, AND 111/0000000, OR 110/0000000, XOR 100/0000000, SLT 010/0000000.
- MEMADR: ULASrcA=10, ULASrcB=01, ULAControl=000. Goes to MEMREAD if Op=0000011, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until MemReady=1, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, Retire=1. Goes to FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1.
  - MemWrite stays asserted while MemReady=0.
  - On MemReady=1: Retire=1, then goes to FETCH.
- EXECR: ULASrcA=10, ULASrcB=00, ULAControl from the funct table above. Goes to ALUWB.
- EXECI: ULASrcA=10, ULASrcB=01, ULAControl = 000 (ADDI) or 011 (ORI). Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, Retire=1. Goes to FETCH.
- BRANCH: ULASrcA=10, ULASrcB=00, ULAControl=001, ResultSrc=00, Retire=1. Goes to FETCH.
  - PCWrite = (Funct3=000 & Zero) | (Funct3=001 & ~Zero).
- JAL: ULASrcA=01, ULASrcB=10, ULAControl=000, ResultSrc=00, PCWrite=1. Goes to ALUWB, which writes OldPC+4 to rd.
- TRAP: Trap=1; all strobes 0. Absorbing state; only reset exits.

## Timing
- State register updates on the clk rising edge; outputs are combinational from state (plus Zero/MemReady/Funct3 where stated).
- Reset asserted:
  - state=FETCH immediately (asynchronous).
  - PCWrite, IRWrite, RegWrite, MemWrite, Retire and Trap are forced to 0 while reset=1.
  - Mux selects show FETCH values.
- Reset mid-instruction: any in-flight MemWrite/RegWrite drops in the same cycle; after release the first active edge may complete a FETCH.
- Latency with MemReady tied 1:
  - BEQ/BNE 3 cycles
  - R-type, I-type, SB, JAL 4 cycles
  - LB 5 cycles
- Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Retire pulses exactly once per non-trapping instruction, in its final cycle.
- PCWrite and IRWrite are never both high outside FETCH.

## Test plan
- ADD (Op=0110011, F3=000, F7=0000000), MemReady=1:
  - Sequence FETCH→DECODE→EXECR→ALUWB.
  - ULAControl=000 in EXECR; RegWrite=1 and Retire=1 only in cycle 4.
- LB with MemReady low 2 cycles in MEMREAD:
  - Total 7 cycles.
  - AdrSrc=1 throughout MEMREAD; ResultSrc=01 with RegWrite=1 in MEMWB.
- BNE with Zero=0 → PCWrite=1 in BRANCH; BEQ with Zero=0 → PCWrite=0. Both take 3 cycles.
- JAL: PCWrite=1 in JAL, then ALUWB with RegWrite=1; ImmSrc=11 throughout.
- SB with MemReady=0 for 3 cycles in MEMWRITE:
  - MemWrite held high for 4 cycles; Retire on the last.
  - Reset asserted mid-wait drops MemWrite in the same cycle and returns to FETCH.
- Op=0110111 (unsupported), or R-type F7=0000001: enters TRAP after DECODE, Trap=1 and stays; reset clears it and FETCH resumes.
